// File: rtl/sine_osc_ctrl.sv
// -----------------------------------------------------------------------------
// sine_osc_ctrl
//   Sequencer for a coupled-recurrence sine oscillator
//   (sin += cos>>>6, cos -= sin>>>6). Accepts a run configuration, seeds the
//   oscillator, paces it with step enables, counts full periods at upward zero
//   crossings of sin, re-seeds when the cos amplitude has drifted, and ends a
//   run cleanly at a zero crossing.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   cfg_valid/ready     configuration handshake (accepted only while idle)
//   cfg_div             osc_step every cfg_div+1 clocks
//   cfg_amp             seed for cos (sin seeded to 0), expected positive
//   cfg_periods         periods to run, 0 = run until stop
//   stop                level request to stop at the next upward crossing
//   sin_val, cos_val    current oscillator registers
//   osc_load, osc_seed  load oscillator (sin<=0, cos<=osc_seed)
//   osc_step            advance oscillator one iteration
//   busy, done          run in progress / one-cycle end-of-run pulse
//   period_cnt          periods completed this run (saturating)
//   reseed_cnt          drift re-seeds this run (saturating at 255)
// -----------------------------------------------------------------------------
module sine_osc_ctrl #(
  parameter int W     = 16,
  parameter int DIV_W = 16,
  parameter int CNT_W = 16,
  parameter int TOL   = 512
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [W-1:0]     cfg_amp,
  input  logic [CNT_W-1:0] cfg_periods,
  input  logic             stop,
  input  logic [W-1:0]     sin_val,
  input  logic [W-1:0]     cos_val,
  output logic             osc_load,
  output logic [W-1:0]     osc_seed,
  output logic             osc_step,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] period_cnt,
  output logic [7:0]       reseed_cnt
);

  typedef enum logic [1:0] {IDLE, SEED, RUN, STOPPING} state_t;

  localparam logic signed [W:0] TOL_S = (W+1)'(TOL);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] divcnt_q, divcnt_d;
  logic [W-1:0]     amp_q, amp_d;
  logic [CNT_W-1:0] periods_q, periods_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic [7:0]       reseed_cnt_q, reseed_cnt_d;
  logic             chk_q, chk_d;
  logic             prev_neg_q, prev_neg_d;

  logic             running;
  logic             neg;
  logic             xup;
  logic             end_run;
  logic             drift;
  logic             step_due;
  logic [CNT_W-1:0] period_inc;
  logic signed [W:0] diff;
  logic signed [W:0] diff_abs;

  assign running    = (state_q == RUN) || (state_q == STOPPING);
  assign neg        = $signed(sin_val) < 0;
  // sin_val is only meaningful the cycle after a step (chk_q).
  assign xup        = running && chk_q && prev_neg_q && !neg;
  assign period_inc = (&period_cnt_q) ? period_cnt_q : period_cnt_q + 1'b1;

  // Drift measured one bit wider than the samples so the difference of two
  // full-range values cannot wrap.
  assign diff     = $signed({cos_val[W-1], cos_val}) - $signed({amp_q[W-1], amp_q});
  assign diff_abs = diff[W] ? -diff : diff;
  assign drift    = diff_abs > TOL_S;

  // A crossing ends the run when stopping was already requested, when stop is
  // raised in that very cycle, or when the requested period count is reached.
  assign end_run  = xup && ((state_q == STOPPING) || stop ||
                            ((periods_q != '0) && (period_inc == periods_q)));
  assign step_due = running && (divcnt_q == div_q);

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    amp_d        = amp_q;
    periods_d    = periods_q;
    period_cnt_d = period_cnt_q;
    reseed_cnt_d = reseed_cnt_q;
    divcnt_d     = divcnt_q;
    prev_neg_d   = prev_neg_q;
    chk_d        = 1'b0;
    cfg_ready    = 1'b0;
    osc_load     = 1'b0;
    osc_seed     = '0;
    osc_step     = 1'b0;
    done         = 1'b0;

    case (state_q)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          div_d        = cfg_div;
          amp_d        = cfg_amp;
          periods_d    = cfg_periods;
          period_cnt_d = '0;
          reseed_cnt_d = '0;
          divcnt_d     = '0;
          state_d      = SEED;
        end
      end
      SEED: begin
        osc_load   = 1'b1;
        osc_seed   = amp_q;
        prev_neg_d = 1'b0;
        divcnt_d   = '0;
        state_d    = RUN;
      end
      RUN, STOPPING: begin
        // No step on the closing cycle so the oscillator rests at the crossing.
        osc_step = step_due && !end_run;
        divcnt_d = step_due ? '0 : divcnt_q + 1'b1;
        chk_d    = osc_step;
        if (chk_q) begin
          prev_neg_d = neg;
        end
        if (xup) begin
          period_cnt_d = period_inc;
        end
        if (end_run) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (xup && drift) begin
          reseed_cnt_d = (&reseed_cnt_q) ? reseed_cnt_q : reseed_cnt_q + 1'b1;
          state_d      = SEED;
        end else if ((state_q == RUN) && stop) begin
          state_d = STOPPING;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      div_q        <= '0;
      divcnt_q     <= '0;
      amp_q        <= '0;
      periods_q    <= '0;
      period_cnt_q <= '0;
      reseed_cnt_q <= '0;
      chk_q        <= 1'b0;
      prev_neg_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      divcnt_q     <= divcnt_d;
      amp_q        <= amp_d;
      periods_q    <= periods_d;
      period_cnt_q <= period_cnt_d;
      reseed_cnt_q <= reseed_cnt_d;
      chk_q        <= chk_d;
      prev_neg_q   <= prev_neg_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign period_cnt = period_cnt_q;
  assign reseed_cnt = reseed_cnt_q;

endmodule

// File: tb/tb_sine_osc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sine_osc_ctrl
//   Drives sine_osc_ctrl against an ideal oscillator model. For every run a
//   reference timeline is derived from the run rules (load at cycle 1, steps
//   every div+1 clocks from the load, period counted at each upward crossing
//   of the modelled sin) and the DUT outputs are compared cycle by cycle.
// -----------------------------------------------------------------------------
module tb_sine_osc_ctrl;

  localparam int MAXC = 6000;
  localparam logic [63:0] RST_VEC = 64'd1 << 44;

  logic        clk;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_div;
  logic [15:0] cfg_amp;
  logic [15:0] cfg_periods;
  logic        stop;
  logic [15:0] sin_val;
  logic [15:0] cos_val;
  logic        osc_load;
  logic [15:0] osc_seed;
  logic        osc_step;
  logic        busy;
  logic        done;
  logic [15:0] period_cnt;
  logic [7:0]  reseed_cnt;

  sine_osc_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_div    (cfg_div),
    .cfg_amp    (cfg_amp),
    .cfg_periods(cfg_periods),
    .stop       (stop),
    .sin_val    (sin_val),
    .cos_val    (cos_val),
    .osc_load   (osc_load),
    .osc_seed   (osc_seed),
    .osc_step   (osc_step),
    .busy       (busy),
    .done       (done),
    .period_cnt (period_cnt),
    .reseed_cnt (reseed_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ideal oscillator; cos_val can be overridden for one cycle to fake drift.
  logic signed [15:0] sin_r;
  logic signed [15:0] cos_r;
  logic               force_en;
  logic [15:0]        force_val;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sin_r <= '0;
      cos_r <= '0;
    end else if (osc_load) begin
      sin_r <= '0;
      cos_r <= osc_seed;
    end else if (osc_step) begin
      sin_r <= sin_r + (cos_r >>> 6);
      cos_r <= cos_r - ((sin_r + (cos_r >>> 6)) >>> 6);
    end
  end

  assign sin_val = sin_r;
  assign cos_val = force_en ? force_val : cos_r;

  wire [63:0] got_vec = {19'd0, cfg_ready, busy, osc_load, osc_step, done,
                         osc_seed, period_cnt, reseed_cnt};

  int n_chk;
  int n_fail;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk(input bit rdy, input bit bsy, input bit ld, input bit st,
                                      input bit dn, input int seed, input int pc, input int rc);
    return {19'd0, rdy, bsy, ld, st, dn, 16'(seed), 16'(pc), 8'(rc)};
  endfunction

  // Reference timeline for one run
  logic [63:0] exp_vec [1:MAXC];
  int          exp_len;
  bit          exp_ended;
  int          exp_force_at;
  int          fin_pc;
  int          fin_rc;

  function automatic void predict(input int div, input int amp, input int periods,
                                  input int stop_at, input int force_off, input int lim);
    shortint s, cs;
    int pc, rc, pc_n, rc_n, load_at, next_step, cos_seen, d;
    bit prev_neg, stepped, stopping, first_x, ld, st, dn, xup, neg;
    s = 0; cs = 0; pc = 0; rc = 0; load_at = 1; next_step = 0;
    prev_neg = 0; stepped = 0; stopping = 0; first_x = 1;
    exp_ended = 0; exp_force_at = -1; exp_len = lim;
    for (int c = 1; c <= lim; c++) begin
      ld = (c == load_at); st = 0; dn = 0; xup = 0; pc_n = pc; rc_n = rc;
      if (!ld) begin
        if (stepped) begin
          neg = (s < 0);
          xup = prev_neg && !neg;
          prev_neg = neg;
        end
        if (xup) begin
          cos_seen = int'(cs);
          if (first_x && force_off != 0) begin
            cos_seen = amp + force_off;
            exp_force_at = c;
          end
          first_x = 0;
          pc_n = (pc < 65535) ? pc + 1 : pc;
          if (stopping || c == stop_at || (periods != 0 && pc_n == periods)) begin
            dn = 1;
          end else begin
            d = cos_seen - amp;
            if (d < 0) d = -d;
            if (d > 512) begin
              rc_n = (rc < 255) ? rc + 1 : rc;
              load_at = c + 1;
            end
          end
        end
        if (!dn && c == next_step) begin
          st = 1;
          next_step = next_step + div + 1;
        end
        if (c == stop_at) stopping = 1;
      end
      exp_vec[c] = mk(0, 1, ld, st, dn, ld ? amp : 0, pc, rc);
      pc = pc_n; rc = rc_n; stepped = st;
      if (ld) begin
        s = 0; cs = shortint'(amp); prev_neg = 0; next_step = c + div + 1;
      end else if (st) begin
        s = s + (cs >>> 6);
        cs = cs - (s >>> 6);
      end
      if (dn) begin
        exp_ended = 1;
        exp_len = c;
        break;
      end
    end
    fin_pc = pc;
    fin_rc = rc;
  endfunction

  task automatic do_reset(input string tag);
    rst_n = 1'b0; stop = 1'b0; force_en = 1'b0; cfg_valid = 1'b0;
    #1;
    check_val(tag, got_vec, RST_VEC);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check_val({tag, "_rel"}, got_vec, RST_VEC);
  endtask

  task automatic run_cfg(input int div, input int amp, input int periods, input int stop_at,
                         input int force_off, input int lim, input bit hold, input int alt_amp,
                         output int steps);
    int f0;
    bit bad;
    predict(div, amp, periods, stop_at, force_off, lim);
    cfg_div = 16'(div); cfg_amp = 16'(amp); cfg_periods = 16'(periods); cfg_valid = 1'b1;
    @(posedge clk); #1;
    if (hold) begin
      cfg_amp = 16'(alt_amp); cfg_div = 16'd0; cfg_periods = 16'd1;
    end else begin
      cfg_valid = 1'b0;
    end
    steps = 0; bad = 0;
    for (int c = 1; c <= exp_len; c++) begin
      stop = (c == stop_at);
      force_en = (c == exp_force_at);
      force_val = 16'(amp + force_off);
      #1;
      f0 = n_fail;
      check_val($sformatf("cyc%0d", c), got_vec, exp_vec[c]);
      if (osc_step) steps++;
      if (n_fail != f0) begin
        bad = 1;
        break;
      end
      if (c < exp_len) begin
        @(posedge clk); #1;
      end
    end
    stop = 1'b0; force_en = 1'b0;
    $display("run div=%0d amp=%0d periods=%0d stop_at=%0d drift=%0d cycles=%0d steps=%0d period_cnt=%0d reseed_cnt=%0d",
             div, amp, periods, stop_at, force_off, exp_len, steps, period_cnt, reseed_cnt);
    if (bad) begin
      do_reset("bail_rst");
      return;
    end
    if (!exp_ended) begin
      do_reset("cut_rst");
      return;
    end
    @(posedge clk); #1;
    check_val("idle", got_vec, mk(1, 0, 0, 0, 0, 0, fin_pc, fin_rc));
    if (hold) begin
      @(posedge clk); #1;
      check_val("reaccept", got_vec, mk(0, 1, 1, 0, 0, alt_amp, 0, 0));
      cfg_valid = 1'b0;
      do_reset("hold_rst");
    end else begin
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        check_val("no_step", got_vec, mk(1, 0, 0, 0, 0, 0, fin_pc, fin_rc));
      end
    end
  endtask

  initial begin
    int steps, div, amp, periods, stop_at, force_off;
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_div = '0; cfg_amp = '0; cfg_periods = '0;
    stop = 1'b0; force_en = 1'b0; force_val = '0;
    #1;
    check_val("rst0", got_vec, RST_VEC);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check_val("rst0_rel", got_vec, RST_VEC);

    // Two periods, step every clock; about 402 steps per period.
    run_cfg(0, 30000, 2, -1, 0, MAXC, 0, 0, steps);
    check_val("steps_per_period", 64'(steps >= 790 && steps <= 815), 64'd1);

    // Step spacing of 5 clocks.
    run_cfg(4, 20000, 1, -1, 0, MAXC, 0, 0, steps);

    // Continuous run stopped mid-period.
    run_cfg(1, 24000, 0, 300, 0, MAXC, 0, 0, steps);

    // Drift beyond and within tolerance at the first crossing.
    run_cfg(0, 25000, 2, -1, 600, MAXC, 0, 0, steps);
    run_cfg(0, 25000, 2, -1, 500, MAXC, 0, 0, steps);

    // cfg_valid held through a run; next config taken right after done.
    run_cfg(1, 16000, 1, -1, 0, MAXC, 1, 12345, steps);

    // Asynchronous reset in the middle of a run.
    run_cfg(3, 20000, 0, -1, 0, 1800, 0, 0, steps);

    for (int r = 0; r < 6; r++) begin
      div = $urandom_range(0, 2);
      amp = $urandom_range(6000, 30000);
      periods = $urandom_range(0, 2);
      if (periods == 0 || $urandom_range(0, 1) == 1) stop_at = $urandom_range(2, 1500);
      else stop_at = -1;
      case ($urandom_range(0, 3))
        0: force_off = 0;
        1: force_off = 500;
        2: force_off = 600;
        default: force_off = $urandom_range(1, 1500);
      endcase
      run_cfg(div, amp, periods, stop_at, force_off, MAXC, 0, 0, steps);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
